// File: rtl/cpu_pkg.sv
// Shared widths, opcodes and fetch state encoding for the 13-bit-address RISC core.
package cpu_pkg;

  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] HLT_OP = 3'b000;
  localparam logic [OPW-1:0] ADD_OP = 3'b001;
  localparam logic [OPW-1:0] SUB_OP = 3'b010;
  localparam logic [OPW-1:0] AND_OP = 3'b011;
  localparam logic [OPW-1:0] OR_OP  = 3'b100;
  localparam logic [OPW-1:0] XOR_OP = 3'b101;
  localparam logic [OPW-1:0] LDA_OP = 3'b110;
  localparam logic [OPW-1:0] JMP_OP = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    DECODE,
    PRESENT,
    JUMP,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads two bytes per instruction, runs JMP/HLT
// locally and hands all other instructions downstream over valid/ready.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [AW-1:0]   pc_addr,
  output logic            inc_pc,
  output logic            load,
  output logic [AW-1:0]   ir_addr,
  output logic [OPW-1:0]  opcode,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_data,
  input  logic            mem_ack,
  output logic            halted
);

  fetch_state_t        state;
  fetch_state_t        next_state;
  logic [2*DW-1:0]     ir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Acks outside REQ_HI/REQ_LO (including ones arriving after a reset) never reach the IR.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= '0;
    end else if (state == REQ_HI && mem_ack) begin
      ir[2*DW-1:DW] <= mem_data;
    end else if (state == REQ_LO && mem_ack) begin
      ir[DW-1:0] <= mem_data;
    end
  end

  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    load       = 1'b0;
    ir_valid   = 1'b0;
    halted     = 1'b0;
    case (state)
      IDLE: begin
        if (ena) next_state = REQ_HI;
      end
      REQ_HI: begin
        mem_rd = 1'b1;
        if (mem_ack) next_state = REQ_LO;
      end
      REQ_LO: begin
        mem_rd = 1'b1;
        if (mem_ack) next_state = DECODE;
      end
      DECODE: begin
        if (opcode == HLT_OP) begin
          next_state = HALT;
        end else if (opcode == JMP_OP) begin
          next_state = JUMP;
        end else begin
          next_state = PRESENT;
        end
      end
      PRESENT: begin
        ir_valid = 1'b1;
        if (ir_ready) next_state = ena ? REQ_HI : IDLE;
      end
      JUMP: begin
        load       = 1'b1;
        next_state = ena ? REQ_HI : IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // inc_pc only exists while a read is outstanding, so it can never overlap load.
  assign inc_pc   = mem_rd & mem_ack;
  assign mem_addr = pc_addr;
  assign opcode   = ir[2*DW-1 -: OPW];
  assign ir_addr  = ir[AW-1:0];

endmodule
